// File: rtl/cobs_pkg.sv
// Shared constants and state encoding for the COBS transmit framer.
package cobs_pkg;

    localparam logic [7:0] COBS_DELIM   = 8'h00;
    localparam int         COBS_RUN_MAX = 254;

    typedef enum logic [2:0] {
        FILL,
        EMIT_CODE,
        EMIT_DATA,
        EMIT_ONE,
        EMIT_DELIM
    } state_e;

endpackage

// File: rtl/cobs_run_buf.sv
// Run buffer: RUN_MAX x 8 synchronous RAM with one write port and a
// registered read port. A read of the address being written this cycle
// returns the new byte, so a group closed on its first byte can still be
// prefetched on the closing edge.
module cobs_run_buf
    import cobs_pkg::*;
#(
    parameter int RUN_MAX = COBS_RUN_MAX
) (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);

    localparam logic [7:0] DEPTH = 8'(RUN_MAX);

    logic [7:0] mem_q [RUN_MAX];
    logic [7:0] rdata_q;

    // Write port: store one non-zero payload byte.
    always_ff @(posedge clk) begin
        if (we && (waddr < DEPTH)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port with same-cycle write forwarding.
    always_ff @(posedge clk) begin
        if (we && (waddr == raddr)) begin
            rdata_q <= wdata;
        end else if (raddr < DEPTH) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cobs_encoder.sv
// COBS framer: collects one group of non-zero bytes, then emits its code
// byte, the buffered data, an optional trailing empty group and the frame
// delimiter. Input is stalled for the whole emission of a group.
module cobs_encoder
    import cobs_pkg::*;
#(
    parameter int RUN_MAX = COBS_RUN_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_done
);

    localparam logic [7:0] RUN_MAX_B = 8'(RUN_MAX);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rd_q, rd_d;
    logic [7:0] out_data_q, out_data_d;
    logic       eof_q, eof_d;
    logic       pend_one_q, pend_one_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       frame_done_q, frame_done_d;

    logic       in_fire;
    logic       out_fire;
    logic       byte_nz;
    logic       buf_we;
    logic       post_group;
    logic [7:0] cnt_inc;
    logic [7:0] raddr;
    logic [7:0] rdata;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;
    assign byte_nz  = (in_data != 8'h00);
    assign cnt_inc  = cnt_q + {7'd0, byte_nz};
    assign buf_we   = in_fire && byte_nz;

    cobs_run_buf #(
        .RUN_MAX (RUN_MAX)
    ) u_run_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (cnt_q),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Next-state, output register and RAM prefetch address. The RAM output
    // always holds the byte that follows the one currently in out_data.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        out_data_d   = out_data_q;
        eof_d        = eof_q;
        pend_one_d   = pend_one_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        raddr        = 8'd0;
        post_group   = 1'b0;

        case (state_q)
            FILL: begin
                in_ready_d = 1'b1;
                if (in_fire) begin
                    cnt_d = cnt_inc;
                    if (!byte_nz || in_last || (cnt_inc == RUN_MAX_B)) begin
                        // Code is the number of stored bytes plus one.
                        out_data_d  = cnt_inc + 8'd1;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        eof_d       = in_last;
                        pend_one_d  = !byte_nz && in_last;
                        state_d     = EMIT_CODE;
                    end
                end
            end
            EMIT_CODE: begin
                raddr = out_fire ? 8'd1 : 8'd0;
                if (out_fire) begin
                    if (cnt_q != 8'd0) begin
                        state_d    = EMIT_DATA;
                        rd_d       = 8'd0;
                        out_data_d = rdata;
                    end else begin
                        post_group = 1'b1;
                    end
                end
            end
            EMIT_DATA: begin
                raddr = rd_q + (out_fire ? 8'd2 : 8'd1);
                if (out_fire) begin
                    if (rd_q == (cnt_q - 8'd1)) begin
                        post_group = 1'b1;
                    end else begin
                        rd_d       = rd_q + 8'd1;
                        out_data_d = rdata;
                    end
                end
            end
            EMIT_ONE: begin
                if (out_fire) begin
                    state_d    = EMIT_DELIM;
                    out_data_d = COBS_DELIM;
                end
            end
            EMIT_DELIM: begin
                if (out_fire) begin
                    frame_done_d = 1'b1;
                    cnt_d        = 8'd0;
                    out_valid_d  = 1'b0;
                    in_ready_d   = 1'b1;
                    state_d      = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        // End of a group: next group, trailing empty group, or delimiter.
        if (post_group) begin
            if (!eof_q) begin
                cnt_d       = 8'd0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = FILL;
            end else if (pend_one_q) begin
                out_data_d = 8'h01;
                state_d    = EMIT_ONE;
            end else begin
                out_data_d = COBS_DELIM;
                state_d    = EMIT_DELIM;
            end
        end
    end

    // State and output registers; reset aborts any partial frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FILL;
            cnt_q        <= 8'd0;
            rd_q         <= 8'd0;
            out_data_q   <= 8'h00;
            eof_q        <= 1'b0;
            pend_one_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            out_data_q   <= out_data_d;
            eof_q        <= eof_d;
            pend_one_q   <= pend_one_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cobs_encoder.sv
// Bench for cobs_encoder: table vectors, hand-built corner frames and
// random frames compared against a queue-based COBS reference.
`timescale 1ns/1ps
module tb_cobs_encoder;

    localparam int RUN_MAX = 254;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       frame_done;

    always #5 clk = ~clk;

    cobs_encoder #(.RUN_MAX(RUN_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    typedef logic [7:0] bq_t [$];

    typedef struct packed {
        logic [7:0]        nin;
        logic [0:7][7:0]   din;
        logic [7:0]        nout;
        logic [0:9][7:0]   dout;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    logic [7:0] got [$];
    int         rdy_mode = 0;
    int         fd_pulses = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Standard COBS with a RUN_MAX-limited group; a trailing zero adds an empty group.
    function automatic bq_t cobs_ref(input bq_t p);
        bq_t o;
        bq_t g;
        for (int i = 0; i < p.size(); i++) begin
            bit last = (i == p.size() - 1);
            if (p[i] == 8'h00) begin
                o.push_back(8'(g.size() + 1));
                foreach (g[k]) o.push_back(g[k]);
                g.delete();
                if (last) o.push_back(8'h01);
            end else begin
                g.push_back(p[i]);
                if (g.size() == RUN_MAX || last) begin
                    o.push_back(8'(g.size() + 1));
                    foreach (g[k]) o.push_back(g[k]);
                    g.delete();
                end
            end
        end
        o.push_back(8'h00);
        return o;
    endfunction

    // out_ready pattern, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Output monitor: collects transfers and checks hold, frame_done and stall rules.
    initial begin
        bit         prev_stall = 1'b0;
        bit         prev_delim = 1'b0;
        logic [7:0] prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
                prev_delim = 1'b0;
            end else begin
                check(frame_done == prev_delim, "frame_done", frame_done, prev_delim);
                if (prev_delim) fd_pulses++;
                if (prev_stall)
                    check(out_valid && out_data == prev_data, "stall_hold",
                          {out_valid, out_data}, {1'b1, prev_data});
                if (out_valid)
                    check(!in_ready, "in_ready_during_emit", in_ready, 0);
                prev_delim = out_valid && out_ready && (out_data == 8'h00);
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                if (out_valid && out_ready) got.push_back(out_data);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the byte transfers.
    task automatic push(input logic [7:0] b, input bit last);
        int guard = 0;
        in_data  = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) check(1'b0, "in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input bq_t p);
        for (int i = 0; i < p.size(); i++) push(p[i], i == p.size() - 1);
    endtask

    task automatic run_frame(input bq_t p, input bq_t exp, input string name);
        int fd0;
        int guard = 0;
        int mism = -1;
        got.delete();
        fd0 = fd_pulses;
        send_frame(p);
        while (got.size() < exp.size() && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        check(got.size() == exp.size(), {name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            if (mism < 0 && got[i] !== exp[i]) mism = i;
        end
        if (mism >= 0) $display("FAIL %s_data at byte %0d", name, mism);
        check(mism < 0, {name, "_data"}, (mism < 0) ? 0 : got[mism], (mism < 0) ? 0 : exp[mism]);
        check(fd_pulses - fd0 == 1, {name, "_frame_done_count"}, fd_pulses - fd0, 1);
    endtask

    initial begin
        vec_t vecs [7];
        bq_t  p;
        bq_t  e;
        int   guard;
        int   fd0;

        vecs[0] = '{nin: 8'd4, din: {8'h11, 8'h22, 8'h00, 8'h33, 32'h0},
                    nout: 8'd6, dout: {8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00, 32'h0}};
        vecs[1] = '{nin: 8'd1, din: {8'h00, 56'h0},
                    nout: 8'd3, dout: {8'h01, 8'h01, 8'h00, 56'h0}};
        vecs[2] = '{nin: 8'd1, din: {8'h05, 56'h0},
                    nout: 8'd3, dout: {8'h02, 8'h05, 8'h00, 56'h0}};
        vecs[3] = '{nin: 8'd2, din: {8'h00, 8'h00, 48'h0},
                    nout: 8'd4, dout: {8'h01, 8'h01, 8'h01, 8'h00, 48'h0}};
        vecs[4] = '{nin: 8'd2, din: {8'h11, 8'h00, 48'h0},
                    nout: 8'd4, dout: {8'h02, 8'h11, 8'h01, 8'h00, 48'h0}};
        vecs[5] = '{nin: 8'd2, din: {8'h00, 8'h11, 48'h0},
                    nout: 8'd4, dout: {8'h01, 8'h02, 8'h11, 8'h00, 48'h0}};
        vecs[6] = '{nin: 8'd3, din: {8'hAA, 8'hBB, 8'hCC, 40'h0},
                    nout: 8'd5, dout: {8'h04, 8'hAA, 8'hBB, 8'hCC, 8'h00, 40'h0}};

        // Reset state
        repeat (3) @(negedge clk);
        check(in_ready == 1'b0, "reset_in_ready", in_ready, 0);
        check(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
        check(out_data == 8'h00, "reset_out_data", out_data, 0);
        check(frame_done == 1'b0, "reset_frame_done", frame_done, 0);
        rst = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "in_ready_after_release", in_ready, 1);

        // Table vectors, full throughput
        rdy_mode = 0;
        foreach (vecs[v]) begin
            p.delete();
            e.delete();
            for (int i = 0; i < vecs[v].nin; i++) p.push_back(vecs[v].din[i]);
            for (int i = 0; i < vecs[v].nout; i++) e.push_back(vecs[v].dout[i]);
            run_frame(p, e, $sformatf("vec%0d", v));
        end

        // Backpressure: toggling out_ready
        rdy_mode = 1;
        p = '{8'h11, 8'h22, 8'h00, 8'h33};
        e = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
        run_frame(p, e, "backpressure");
        rdy_mode = 0;

        // Full run of 254 bytes, no trailing empty group
        p.delete();
        e.delete();
        e.push_back(8'hFF);
        for (int i = 1; i <= 254; i++) begin
            p.push_back(8'(i));
            e.push_back(8'(i));
        end
        e.push_back(8'h00);
        run_frame(p, e, "full_run");

        // Run overflow: 255 bytes splits into two groups
        p.delete();
        e.delete();
        e.push_back(8'hFF);
        for (int i = 1; i <= 254; i++) begin
            p.push_back(8'(i));
            e.push_back(8'(i));
        end
        p.push_back(8'hFF);
        e.push_back(8'h02);
        e.push_back(8'hFF);
        e.push_back(8'h00);
        run_frame(p, e, "run_overflow");

        // Reset mid-emission
        p.delete();
        for (int i = 1; i <= 10; i++) p.push_back(8'(i));
        got.delete();
        fd0 = fd_pulses;
        send_frame(p);
        guard = 0;
        while (got.size() < 3 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check(guard < 1000, "mid_emit_reach", guard, 0);
        rst = 1'b0;
        @(negedge clk);
        check(out_valid == 1'b0, "abort_out_valid", out_valid, 0);
        check(in_ready == 1'b0, "abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "abort_in_ready_release", in_ready, 1);
        check(fd_pulses == fd0, "abort_no_frame_done", fd_pulses - fd0, 0);
        p = '{8'h05};
        e = '{8'h02, 8'h05, 8'h00};
        run_frame(p, e, "after_abort");

        // Random frames against the reference model
        for (int f = 0; f < 40; f++) begin
            int len;
            int zp;
            rdy_mode = $urandom_range(0, 2);
            zp = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) begin
                len = $urandom_range(200, 520);
                zp = 0;
            end else begin
                len = $urandom_range(1, 24);
            end
            p.delete();
            for (int i = 0; i < len; i++) begin
                bit z;
                case (zp)
                    0:       z = ($urandom_range(0, 99) == 0);
                    1:       z = ($urandom_range(0, 7) == 0);
                    default: z = ($urandom_range(0, 1) == 0);
                endcase
                p.push_back(z ? 8'h00 : 8'($urandom_range(1, 255)));
            end
            e = cobs_ref(p);
            run_frame(p, e, $sformatf("rand%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cobs_encoder.md
# cobs_encoder

Byte-stream COBS framer for the UART transmit path. It accepts raw payload bytes with a last-byte marker and emits a COBS-encoded stream terminated by a 0x00 delimiter, ready for a byte-wide UART transmitter. It mirrors the receive-side COBS decoder, so the host's standard COBS decoder reconstructs every frame exactly.

## Interface
- RUN_MAX, default 254: maximum non-zero run per group. Legal range 1..254. Values below 254 are for simulation only.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_data  in  8  payload byte
- in_valid  in  1  in_data/in_last valid
- in_last  in  1  byte is final byte of frame
- in_ready  out  1  encoder accepts a byte this cycle
- out_data  out  8  encoded byte to UART TX
- out_valid  out  1  out_data valid
- out_ready  in  1  UART TX accepts out_data (not busy)
- frame_done  out  1  one-cycle pulse when the delimiter transfers

## Operation
- Transfer rules: input transfers when in_valid&&in_ready; output transfers when out_valid&&out_ready.
- States:
  - FILL: in_ready=1, out_valid=0.
    - Non-zero byte: written to the run buffer at index cnt; cnt+1.
    - Group closes on any of:
      - zero byte: code=cnt+1, zero not stored;
      - cnt reaches RUN_MAX: code=RUN_MAX+1, 0xFF at 254;
      - in_last.
    - On close, latch code, latch pend_one, latch eof=in_last, go to EMIT_CODE.
  - EMIT_CODE: out_data=code. On transfer: if cnt>0, go to EMIT_DATA with rd=0; otherwise go to the post-group step.
  - EMIT_DATA: out_data=buf[rd]. On transfer rd+1. After the rd=cnt-1 transfer, do the post-group step.
  - Post-group step:
    - If eof is clear: cnt=0, go to FILL.
    - If eof is set and pend_one is set: go to EMIT_ONE.
    - Otherwise: go to EMIT_DELIM.
  - EMIT_ONE: out_data=0x01. On transfer go to EMIT_DELIM.
  - EMIT_DELIM: out_data=0x00. On transfer pulse frame_done, cnt=0, go to FILL.
- pend_one is set only when the closing byte was a zero with in_last. That case needs a trailing empty group 0x01.
- A group closed by RUN_MAX with in_last emits no extra group.
- A group closed by RUN_MAX without in_last starts a fresh group. A zero arriving next produces code 0x01.
- cnt is 8 bits, range 0..RUN_MAX. rd is 8 bits. The code arithmetic never exceeds 0xFF.
- No fill-while-emit: input stalls for the whole emission of a group.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0x00, frame_done=0. State is FILL, cnt=0.
- in_ready goes to 1 on the first cycle after reset release.
- Reset mid-operation:
  - Any state aborts. The buffered bytes and partial frame are discarded; no delimiter is sent.
  - out_valid=0 on the cycle after rst is sampled low.
- Input throughput: 1 byte/cycle in FILL.
- in_ready is 0 from the cycle after a closing transfer until the cycle after the group's last output transfer.
- Latency: code byte out_valid=1 on the cycle after the closing input transfer.
- Data bytes: one per cycle while out_ready=1, with no bubbles between code, data, 0x01 and delimiter. out_data is registered, so the sync RAM read must be prefetched.
- Stability: while out_valid&&!out_ready, out_data and out_valid hold stable.
- frame_done is registered and high on the cycle after the delimiter transfer.
- in_data/in_last are ignored when in_ready=0.

## Structure
- Package cobs_pkg:
  - COBS_DELIM=8'h00;
  - COBS_RUN_MAX=254;
  - state enum {FILL, EMIT_CODE, EMIT_DATA, EMIT_ONE, EMIT_DELIM}.
- Sub-module cobs_run_buf: RUN_MAX×8 synchronous RAM, with one write port and one registered read port.
- The encoder FSM, counters and output register live in cobs_encoder.

## Test plan
- Mixed frame: 11 22 00 33 (last on 33), out_ready=1 -> 03 11 22 02 33 00. frame_done pulses once.
- Trailing zero: single 00 with in_last -> 01 01 00.
- Full run: 254 bytes 01..FE, last on FE -> FF 01..FE 00, with no 0x01 before the delimiter.
- Run overflow: 255 bytes 01..FF, last on FF -> FF 01..FE 02 FF 00. in_ready is 0 during the first group's emission.
- Backpressure: frame 11 22 00 33 with out_ready toggling every cycle -> identical sequence 03 11 22 02 33 00. No dropped or duplicated bytes, and out_data is stable while stalled.
- Reset mid-emission: drop rst during EMIT_DATA -> out_valid=0 next cycle and in_ready=1 after release. A following frame 05 (last) -> 02 05 00.
